reg_file_mp: RTL and testbench

REG_FILE_MP -- requirements
Module: reg_file_mp

---
 rtl/reg_file_mp.sv | 102 ++++++++++
 tb/tb_reg_file_mp.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// Multi-ported register file with a per-register busy scoreboard and optional write-to-read bypass.
// Reads are combinational, writes and scoreboard updates commit on the rising edge; there is no backpressure.
module reg_file_mp #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRP    = 2,
    parameter int NWP    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NWP-1:0]      we_i,
    input  logic [NWP*AW-1:0]   waddr_i,
    input  logic [NWP*XLEN-1:0] wdata_i,
    input  logic [NRP*AW-1:0]   raddr_i,
    output logic [NRP*XLEN-1:0] rdata_o,
    output logic [NRP-1:0]      rbusy_o,
    input  logic                iss_valid_i,
    input  logic [AW-1:0]       iss_rd_i,
    output logic [AW:0]         busy_cnt_o
);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_busy;
    logic [AW:0]      r_cnt;
    logic [NREGS-1:0] w_busy_nxt;
    logic [AW:0]      w_cnt_nxt;

    // Entry 0 is cleared by reset and never written, so it always reads as zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                for (int p = 0; p < NWP; p++) begin
                    if (we_i[p] && waddr_i[p*AW +: AW] == AW'(i)) begin
                        r_regs[i] <= wdata_i[p*XLEN +: XLEN];
                    end
                end
            end
        end
    end

    // Clears are applied before the set so an issue to the same register wins.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int p = 0; p < NWP; p++) begin
            if (we_i[p] && waddr_i[p*AW +: AW] != '0) begin
                w_busy_nxt[waddr_i[p*AW +: AW]] = 1'b0;
            end
        end
        if (iss_valid_i && iss_rd_i != '0) begin
            w_busy_nxt[iss_rd_i] = 1'b1;
        end
        w_cnt_nxt = '0;
        for (int i = 0; i < NREGS; i++) begin
            w_cnt_nxt = w_cnt_nxt + {{AW{1'b0}}, w_busy_nxt[i]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    assign busy_cnt_o = r_cnt;

    for (genvar r = 0; r < NRP; r++) begin : g_rd
        logic [AW-1:0]   w_ra;
        logic [XLEN-1:0] w_rdata;
        logic            w_rbusy;

        assign w_ra = raddr_i[r*AW +: AW];

        always_comb begin
            w_rdata = r_regs[w_ra];
            w_rbusy = r_busy[w_ra];
            if (BYPASS != 0) begin
                for (int p = 0; p < NWP; p++) begin
                    if (we_i[p] && waddr_i[p*AW +: AW] == w_ra && w_ra != '0) begin
                        w_rdata = wdata_i[p*XLEN +: XLEN];
                        if (!(iss_valid_i && iss_rd_i == w_ra)) begin
                            w_rbusy = 1'b0;
                        end
                    end
                end
            end
        end

        assign rdata_o[r*XLEN +: XLEN] = w_rdata;
        assign rbusy_o[r]              = w_rbusy;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Randomized and directed bench for reg_file_mp against an array-based reference model.
module tb_reg_file_mp;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRP   = 2;
    localparam int NWP   = 2;
    localparam int AW    = 5;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NWP-1:0]      we;
    logic [NWP*AW-1:0]   waddr;
    logic [NWP*XLEN-1:0] wdata;
    logic [NRP*AW-1:0]   raddr;
    logic [NRP*XLEN-1:0] rdata;
    logic [NRP-1:0]      rbusy;
    logic                iss_valid;
    logic [AW-1:0]       iss_rd;
    logic [AW:0]         busy_cnt;

    logic [XLEN-1:0]  m_regs [NREGS];
    logic [NREGS-1:0] m_busy;
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRP(NRP), .NWP(NWP), .BYPASS(1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
        .raddr_i(raddr), .rdata_o(rdata), .rbusy_o(rbusy),
        .iss_valid_i(iss_valid), .iss_rd_i(iss_rd), .busy_cnt_o(busy_cnt)
    );

    task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREGS; i++) m_regs[i] = '0;
        m_busy = '0;
    endtask

    task automatic set_in(input logic [1:0] w, input int wa0, input logic [31:0] wd0,
                          input int wa1, input logic [31:0] wd1,
                          input int ra0, input int ra1, input logic iv, input int ird);
        we        = w;
        waddr     = {AW'(wa1), AW'(wa0)};
        wdata     = {wd1, wd0};
        raddr     = {AW'(ra1), AW'(ra0)};
        iss_valid = iv;
        iss_rd    = AW'(ird);
    endtask

    // Expected reads: stored value, replaced by the last enabled matching writer.
    task automatic check_outs();
        for (int r = 0; r < NRP; r++) begin
            logic [AW-1:0]   ra;
            logic [XLEN-1:0] ev;
            logic            eb;
            logic            fwd;
            ra  = raddr[r*AW +: AW];
            ev  = (ra == 0) ? '0 : m_regs[ra];
            eb  = m_busy[ra];
            fwd = 1'b0;
            for (int p = 0; p < NWP; p++) begin
                if (we[p] && waddr[p*AW +: AW] == ra && ra != 0) begin
                    ev  = wdata[p*XLEN +: XLEN];
                    fwd = 1'b1;
                end
            end
            if (fwd && !(iss_valid && iss_rd == ra)) eb = 1'b0;
            chk($sformatf("rdata%0d", r), rdata[r*XLEN +: XLEN], ev);
            chk($sformatf("rbusy%0d", r), {31'b0, rbusy[r]}, {31'b0, eb});
        end
        chk("busy_cnt", {26'b0, busy_cnt}, XLEN'($countones(m_busy)));
    endtask

    task automatic tick();
        #2;
        check_outs();
        @(posedge clk);
        if (rst_n) begin
            for (int p = 0; p < NWP; p++) begin
                if (we[p] && waddr[p*AW +: AW] != 0) begin
                    m_regs[waddr[p*AW +: AW]] = wdata[p*XLEN +: XLEN];
                    m_busy[waddr[p*AW +: AW]] = 1'b0;
                end
            end
            if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
        end
        #1;
    endtask

    initial begin
        model_reset();
        set_in(2'b00, 0, 0, 0, 0, 0, 0, 1'b0, 0);
        #1;
        chk("reset_cnt", {26'b0, busy_cnt}, 32'd0);
        check_outs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Write x5 on port 0, read it back on both ports.
        set_in(2'b01, 5, 32'hDEADBEEF, 0, 0, 0, 0, 1'b0, 0);
        tick();
        set_in(2'b00, 0, 0, 0, 0, 5, 5, 1'b0, 0);
        #1;
        chk("x5_p0", rdata[31:0], 32'hDEADBEEF);
        chk("x5_p1", rdata[63:32], 32'hDEADBEEF);
        tick();

        // x0 is hardwired: writes dropped, never busy.
        set_in(2'b01, 0, 32'h1234, 0, 0, 0, 0, 1'b1, 0);
        tick();
        set_in(2'b00, 0, 0, 0, 0, 0, 0, 1'b0, 0);
        #1;
        chk("x0_read", rdata[31:0], 32'd0);
        chk("x0_cnt", {26'b0, busy_cnt}, 32'd0);
        tick();

        // Both ports write x7: port 1 wins, also on the bypass path.
        set_in(2'b11, 7, 32'hAAAA, 7, 32'h5555, 7, 7, 1'b0, 0);
        #1;
        chk("x7_bypass", rdata[31:0], 32'h5555);
        tick();
        set_in(2'b00, 0, 0, 0, 0, 7, 0, 1'b0, 0);
        #1;
        chk("x7_stored", rdata[31:0], 32'h5555);
        tick();

        // Issue x3 then write x3 while re-issuing: set beats clear.
        set_in(2'b00, 0, 0, 0, 0, 3, 0, 1'b1, 3);
        tick();
        set_in(2'b01, 3, 32'h33, 0, 0, 3, 0, 1'b1, 3);
        tick();
        set_in(2'b00, 0, 0, 0, 0, 3, 0, 1'b0, 0);
        #1;
        chk("x3_busy", {31'b0, rbusy[0]}, 32'd1);
        chk("x3_cnt", {26'b0, busy_cnt}, 32'd1);
        set_in(2'b01, 3, 32'h34, 0, 0, 3, 0, 1'b0, 0);
        tick();

        // Issue x1, x2, x3 then retire x2.
        for (int i = 1; i <= 3; i++) begin
            set_in(2'b00, 0, 0, 0, 0, 2, 0, 1'b1, i);
            tick();
            chk($sformatf("cnt_after_x%0d", i), {26'b0, busy_cnt}, 32'(i));
        end
        set_in(2'b01, 2, 32'h22, 0, 0, 2, 0, 1'b0, 0);
        #1;
        chk("x2_rbusy_bypass", {31'b0, rbusy[0]}, 32'd0);
        tick();
        set_in(2'b00, 0, 0, 0, 0, 2, 0, 1'b0, 0);
        #1;
        chk("x2_cnt", {26'b0, busy_cnt}, 32'd2);
        chk("x2_rbusy", {31'b0, rbusy[0]}, 32'd0);

        // Async reset mid-cycle with x9 written and four registers busy.
        set_in(2'b01, 9, 32'hFF, 0, 0, 0, 0, 1'b1, 4);
        tick();
        set_in(2'b00, 0, 0, 0, 0, 9, 0, 1'b1, 5);
        tick();
        chk("pre_reset_cnt", {26'b0, busy_cnt}, 32'd4);
        set_in(2'b00, 0, 0, 0, 0, 9, 0, 1'b0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_x9", rdata[31:0], 32'd0);
        chk("rst_cnt", {26'b0, busy_cnt}, 32'd0);
        set_in(2'b01, 9, 32'h77, 0, 0, 9, 0, 1'b1, 9);
        #1;
        chk("rst_bypass", rdata[31:0], 32'h77);
        tick();
        set_in(2'b00, 0, 0, 0, 0, 9, 0, 1'b0, 0);
        #1;
        chk("rst_write_ignored", rdata[31:0], 32'd0);
        chk("rst_issue_ignored", {26'b0, busy_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Random traffic on a small address window to force collisions.
        for (int n = 0; n < 600; n++) begin
            set_in(2'($urandom_range(0, 3)), $urandom_range(0, 7), $urandom,
                   $urandom_range(0, 7), $urandom,
                   $urandom_range(0, 7), $urandom_range(0, 7),
                   1'($urandom_range(0, 1)), $urandom_range(0, 7));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
